// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller.
// Holds the CPU op encoding, response error codes, controller FSM state
// encoding, the default wait-for-ack limit and small op-decoding helpers.
package mem_access_ctrl_pkg;

    // CPU access op codes as presented on req_op.
    typedef enum logic [2:0] {
        OpLb  = 3'b000,
        OpLbu = 3'b001,
        OpLh  = 3'b010,
        OpLhu = 3'b011,
        OpLw  = 3'b100,
        OpSb  = 3'b101,
        OpSh  = 3'b110,
        OpSw  = 3'b111
    } op_e;

    // Response error codes as presented on rsp_err.
    typedef enum logic [1:0] {
        ErrOk         = 2'b00,
        ErrMisaligned = 2'b01,
        ErrTimeout    = 2'b10
    } rsp_err_e;

    // Controller FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StResp  = 2'b10
    } state_e;

    // Default number of cycles mem_req is held waiting for mem_ack.
    localparam int unsigned TimeoutDefault = 16;

    function automatic logic is_store(input op_e op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one; byte ops never fault.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            OpLh, OpLhu, OpSh: mis = addr_lo[0];
            OpLw, OpSw:        mis = (addr_lo != 2'b00);
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane alignment for the memory access controller.
// Ports:
//   op       - captured access op
//   addr_lo  - low two address bits selecting the byte lane(s)
//   st_data  - right-justified store data
//   ld_word  - raw word returned by memory
//   be       - byte enables for the access (all lanes for loads)
//   st_word  - lane-replicated store data (0 for loads)
//   ld_data  - selected and sign/zero-extended load result
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ld_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        be      = 4'b1111;
        st_word = '0;
        ld_data = ld_word;

        case (op)
            OpLb:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   ld_data = {24'b0, byte_sel};
            OpLh:    ld_data = {{16{half_sel[15]}}, half_sel};
            OpLhu:   ld_data = {16'b0, half_sel};
            OpLw:    ld_data = ld_word;
            OpSb: begin
                be      = 4'b0001 << addr_lo;
                st_word = {4{st_data[7:0]}};
            end
            OpSh: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_data[15:0]}};
            end
            OpSw:    st_word = st_data;
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU-to-memory access controller.
// Accepts one load/store in IDLE, checks alignment, drives a word-aligned
// memory access until acknowledged or timed out, then returns a one-cycle
// response with extended load data and an error code.
// Ports:
//   clk, rst_n                          - clock, async active-low reset
//   req_valid/req_op/req_addr/req_wdata - CPU request (taken when req_ready)
//   req_ready                           - high only in IDLE
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata - memory access, held during ISSUE
//   mem_ack/mem_rdata                   - memory completion and read word
//   rsp_valid/rsp_data/rsp_err          - one-cycle response
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_err_q, rsp_err_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ldata;

    mem_lane_align u_lane_align (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (mem_rdata),
        .be      (lane_be),
        .st_word (lane_wdata),
        .ld_data (lane_ldata)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d       = op_e'(req_op);
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    cnt_d      = '0;
                    rsp_data_d = '0;
                    if (is_misaligned(op_e'(req_op), req_addr[1:0])) begin
                        rsp_err_d = ErrMisaligned;
                        state_d   = StResp;
                    end else begin
                        rsp_err_d = ErrOk;
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: begin
                if (mem_ack) begin
                    rsp_err_d  = ErrOk;
                    rsp_data_d = is_store(op_q) ? '0 : lane_ldata;
                    state_d    = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without an ack: give up.
                    rsp_err_d  = ErrTimeout;
                    rsp_data_d = '0;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OpLb;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= ErrOk;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them at once.
    always_comb begin
        req_ready = (state_q == StIdle);
        mem_req   = (state_q == StIssue);
        mem_we    = mem_req && is_store(op_q);
        mem_be    = mem_req ? lane_be : 4'b0000;
        mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
        mem_wdata = mem_req ? lane_wdata : '0;
        rsp_valid = (state_q == StResp);
        rsp_data  = rsp_valid ? rsp_data_q : '0;
        rsp_err   = rsp_valid ? rsp_err_q : 2'b00;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes expected memory
// accesses and responses computed from a byte/half/word reference model; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int unsigned at;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int unsigned len;
    } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd5: return 1;
            3'd2, 3'd3, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic bit op_signed(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd2);
    endfunction

    function automatic bit misaligned(input logic [2:0] op, input logic [31:0] addr);
        return (addr % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] size_mask(input int unsigned size);
        if (size == 4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * size)) - 32'd1;
    endfunction

    function automatic int unsigned lane_off(input logic [2:0] op, input logic [31:0] addr);
        int unsigned size;
        size = op_size(op);
        return ((addr % 4) / size) * size;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned size;
        logic [31:0] mask;
        logic [31:0] v;
        size = op_size(op);
        mask = size_mask(size);
        v = (rdata >> (8 * lane_off(op, addr))) & mask;
        if (op_signed(op) && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
        int unsigned size;
        if (!op_store(op)) return 4'hF;
        size = op_size(op);
        return 4'(((1 << size) - 1) << lane_off(op, addr));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
        int unsigned size;
        logic [31:0] rep;
        size = op_size(op);
        rep = '0;
        for (int k = 0; k < 4 / size; k++) rep = rep | ((wd & size_mask(size)) << (8 * size * k));
        return rep;
    endfunction

    // ---------------- driver ----------------
    // delay = number of ISSUE cycles before the one carrying mem_ack; delay >= TO means no ack.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int unsigned delay);
        bit          mis;
        bit          acked;
        int unsigned ncyc;
        int unsigned w;
        rsp_t        r;
        mem_t        m;
        mis   = misaligned(op, addr);
        acked = delay < TO;
        ncyc  = acked ? delay + 1 : TO;

        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check32("req_ready_idle", 32'(req_ready), 32'd1);

        r.err  = mis ? 2'b01 : (acked ? 2'b00 : 2'b10);
        r.data = (mis || !acked || op_store(op)) ? 32'd0 : load_val(op, addr, rdata);
        r.at   = cyc + (mis ? 1 : ncyc + 1);
        rsp_q.push_back(r);
        if (!mis) begin
            m.addr  = {addr[31:2], 2'b00};
            m.we    = op_store(op);
            m.be    = exp_be(op, addr);
            m.wdata = exp_wdata(op, wd);
            m.len   = ncyc;
            mem_q.push_back(m);
        end

        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        if (!mis) begin
            for (int i = 0; i < int'(ncyc); i++) begin
                mem_ack   = (i == int'(delay));
                mem_rdata = (i == int'(delay)) ? rdata : $urandom;
                // Junk requests while busy must be ignored; drop before RESP.
                req_valid = (i + 1 < int'(ncyc)) ? 1'($urandom) : 1'b0;
                @(posedge clk);
                #1;
            end
            req_valid = 1'b0;
            mem_ack   = !acked;  // late ack during RESP after a timeout
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    int unsigned held = 0;
    mem_t        mon_m;
    rsp_t        mon_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_m = mem_q[0];
                    check32("mem_addr", mem_addr, mon_m.addr);
                    check32("mem_we", 32'(mem_we), 32'(mon_m.we));
                    check32("mem_be", 32'(mem_be), 32'(mon_m.be));
                    if (mon_m.we) check32("mem_wdata", mem_wdata, mon_m.wdata);
                end
                held++;
            end else if (held != 0) begin
                if (mem_q.size() != 0) begin
                    mon_m = mem_q.pop_front();
                    check32("mem_req_cycles", held, mon_m.len);
                end
                held = 0;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check32("rsp_data", rsp_data, mon_r.data);
                    check32("rsp_err", 32'(rsp_err), 32'(mon_r.err));
                    check32("rsp_cycle", cyc, mon_r.at);
                    check32("mem_req_in_resp", 32'(mem_req), 32'd0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check32({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check32({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check32({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check32({tag, "_mem_addr"}, mem_addr, 32'd0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check32({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check32({tag, "_rsp_data"}, rsp_data, 32'd0);
        check32({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        int unsigned sel;
        int unsigned dly;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        do_txn(3'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);          // lb sign-extend
        do_txn(3'd3, 32'h0000_2002, 32'h0, 32'h9ABC_0000, 0);          // lhu upper half
        do_txn(3'd6, 32'h0000_3002, 32'h0000_BEEF, 32'h1234_5678, 3);  // sh after 3 waits
        do_txn(3'd4, 32'h0000_4001, 32'h0, 32'h0, 0);                  // lw misaligned
        do_txn(3'd4, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, TO + 2);     // lw timeout
        do_txn(3'd5, 32'h0000_5001, 32'h0000_00A5, 32'h0, TO - 1);     // sb, ack on last cycle
        do_txn(3'd2, 32'h0000_6003, 32'h0, 32'h0, 0);                  // lh misaligned

        // Reset while an access is outstanding.
        begin
            mem_t m;
            m.addr  = 32'h0000_7000;
            m.we    = 1'b0;
            m.be    = 4'hF;
            m.wdata = '0;
            m.len   = 0;
            mem_q.push_back(m);
            req_valid = 1'b1;
            req_op    = 3'd4;
            req_addr  = 32'h0000_7000;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_issue_reset");
            mem_q.delete();
            rsp_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        do_txn(3'd1, 32'h0000_8002, 32'h0, 32'h00F0_0000, 1);          // lbu right after reset

        for (int n = 0; n < 300; n++) begin
            op   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(3) != 0) addr = addr & ~(op_size(op) - 1);
            sel = $urandom_range(9);
            if (sel < 7)      dly = $urandom_range(3);
            else if (sel < 9) dly = $urandom_range(TO - 1);
            else              dly = TO + $urandom_range(2);
            do_txn(op, addr, $urandom, $urandom, dly);
        end

        repeat (3) @(posedge clk);
        #1;
        check32("rsp_queue_drained", rsp_q.size(), 32'd0);
        check32("mem_queue_drained", mem_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles mem_req is held awaiting mem_ack.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  CPU access request.
REQ-005 req_op  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 sb, 110 sh, 111 sw.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data, right-justified.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 mem_req  out  1  memory access strobe.
REQ-010 mem_we  out  1  1 = write.
REQ-011 mem_be  out  4  byte enables, bit i = byte lane i.
REQ-012 mem_addr  out  32  {req_addr[31:2],2'b00}.
REQ-013 mem_wdata  out  32  lane-replicated store data.
REQ-014 mem_ack  in  1  memory completion.
REQ-015 mem_rdata  in  32  read word, valid with mem_ack.
REQ-016 rsp_valid  out  1  one-cycle response strobe.
REQ-017 rsp_data  out  32  extended load result; 0 for stores and errors.
REQ-018 rsp_err  out  2  00 ok, 01 misaligned, 10 timeout.

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, RESP; req_ready = 1 only in IDLE.
REQ-020 IDLE: req_valid=1 captures op/addr/wdata; aligned -> ISSUE, misaligned -> RESP with rsp_err=01, no mem_req.
REQ-021 Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; byte ops never misaligned.
REQ-022 ISSUE: mem_req=1, mem_addr/mem_we/mem_be/mem_wdata stable, held until mem_ack sampled 1 (ack in first ISSUE cycle allowed).
REQ-023 Load ack: capture extended mem_rdata, go RESP, rsp_err=00.
REQ-024 Extension: lb/lbu select byte addr[1:0] sign/zero-extended; lh/lhu select half addr[1] sign/zero-extended; lw whole word.
REQ-025 Stores: sb be=4'b0001<<addr[1:0], wdata={4{byte}}; sh be=addr[1]?1100:0011, wdata={2{half}}; sw be=1111; loads be=1111, we=0.
REQ-026 Wait counter cleared on ISSUE entry, incremented each ISSUE cycle without ack; reaching TIMEOUT -> RESP with rsp_err=10, mem_req dropped.
REQ-027 mem_ack outside ISSUE (late ack after timeout) SHALL be ignored.
REQ-028 RESP: rsp_valid=1 exactly one cycle, no backpressure, then IDLE.
REQ-029 Latency: accept cycle N, mem_req from N+1, ack at N+1 -> rsp_valid N+2; misaligned -> rsp_valid N+1.
REQ-030 req_valid in ISSUE/RESP SHALL be ignored (not queued).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, counter 0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=00, req_ready=1 after release.
REQ-032 Reset mid-ISSUE SHALL abandon the access without response; first post-reset cycle accepts a new request.

Structure
REQ-033 Shared package/header SHALL hold op codes, rsp_err codes, FSM state encoding, TIMEOUT default.
REQ-034 One sub-module mem_lane_align (combinational): op+addr[1:0]+data -> mem_be, mem_wdata, extended load data.

Verification
REQ-035 lb addr 0x1003, mem_rdata 0x80FF_1234 ack at N+1 -> rsp_data 0xFFFF_FF80, err 00, rsp_valid N+2.
REQ-036 lhu addr 0x2002, mem_rdata 0x9ABC_0000 -> rsp_data 0x0000_9ABC; mem_addr 0x2000, be 1111.
REQ-037 sh addr 0x3002 wdata 0x0000_BEEF -> mem_we 1, be 1100, mem_wdata 0xBEEF_BEEF; ack after 3 waits -> rsp_data 0, err 00.
REQ-038 lw addr 0x4001 -> rsp_valid N+1, err 01, mem_req never asserted.
REQ-039 lw with mem_ack held 0 -> mem_req high TIMEOUT cycles, err 10; ack one cycle later ignored, rsp_valid single.
REQ-040 rst_n low during ISSUE -> mem_req 0 same cycle, no rsp_valid, req_ready 1 after release.
